// File: rtl/decoded_instr_queue_if.sv
// Decoded-instruction entry type plus the decoder/issue handshake bundle
// that connects the decoder, the instruction queue and the issue stage.
package decoded_instr_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } scoreboard_entry_t;
endpackage

interface decoded_instr_queue_if;
    decoded_instr_pkg::scoreboard_entry_t instr_i;
    logic                                 instr_valid_i;
    logic                                 is_ctrl_flow_i;
    logic                                 instr_ready_o;
    decoded_instr_pkg::scoreboard_entry_t decoded_instr_o;
    logic                                 decoded_instr_valid_o;
    logic                                 is_ctrl_flow_o;
    logic                                 decoded_instr_ack_i;

    // master: decoder + issue stage side; slave: the queue itself
    modport master (
        output instr_i, instr_valid_i, is_ctrl_flow_i, decoded_instr_ack_i,
        input  instr_ready_o, decoded_instr_o, decoded_instr_valid_o, is_ctrl_flow_o
    );
    modport slave (
        input  instr_i, instr_valid_i, is_ctrl_flow_i, decoded_instr_ack_i,
        output instr_ready_o, decoded_instr_o, decoded_instr_valid_o, is_ctrl_flow_o
    );
endinterface

// File: rtl/decoded_instr_queue.sv
// FIFO of decoded instructions feeding the issue stage; optionally blocks
// issue after a control-flow instruction until the branch resolves.
module decoded_instr_queue #(
    parameter int unsigned NR_ENTRIES         = 4,
    parameter bit          STALL_ON_CTRL_FLOW = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  resolve_branch_i,
    decoded_instr_queue_if.slave  bus
);
    localparam int unsigned PW = $clog2(NR_ENTRIES);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {IDLE, WAIT_BR} state_e;

    decoded_instr_pkg::scoreboard_entry_t mem_q [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] ctrl_q;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    state_e        state_q, state_d;

    logic full, empty, push, pop;

    always_comb begin
        full  = (cnt_q == CW'(NR_ENTRIES));
        empty = (cnt_q == '0);

        bus.instr_ready_o         = ~full & ~flush_i;
        bus.decoded_instr_valid_o = ~empty & (state_q == IDLE);
        // Storage is not reset, so the head is masked while nothing is buffered
        bus.decoded_instr_o       = empty ? '0 : mem_q[rd_ptr_q];
        bus.is_ctrl_flow_o        = ~empty & ctrl_q[rd_ptr_q];

        push = bus.instr_valid_i & bus.instr_ready_o;
        pop  = bus.decoded_instr_valid_o & bus.decoded_instr_ack_i;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        state_d  = state_q;

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
            state_d  = IDLE;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
            // resolve is deliberately ignored in IDLE, even alongside the ctrl-flow pop
            case (state_q)
                IDLE:    if (STALL_ON_CTRL_FLOW && pop && bus.is_ctrl_flow_o) state_d = WAIT_BR;
                WAIT_BR: if (resolve_branch_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            state_q  <= IDLE;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q]  <= bus.instr_i;
            ctrl_q[wr_ptr_q] <= bus.is_ctrl_flow_i;
        end
    end
endmodule

// File: tb/tb_decoded_instr_queue.sv
// Directed bench for decoded_instr_queue: ordering, full/back-pressure,
// ctrl-flow stall, flush, pointer wrap and asynchronous reset.
module tb_decoded_instr_queue;
    import decoded_instr_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni, flush_i, resolve_branch_i;
    int   vectors = 0;
    int   errs    = 0;

    decoded_instr_queue_if bus ();

    decoded_instr_queue #(.NR_ENTRIES(4), .STALL_ON_CTRL_FLOW(1'b1)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .resolve_branch_i (resolve_branch_i),
        .bus              (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    function automatic scoreboard_entry_t mk(input logic [31:0] pc);
        scoreboard_entry_t e;
        e.pc  = pc;
        e.op  = pc[9:2];
        e.rd  = pc[6:2];
        e.rs1 = pc[7:3];
        e.rs2 = pc[8:4];
        e.imm = ~pc;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic ctrl);
        bus.instr_valid_i  = 1'b1;
        bus.instr_i        = mk(pc);
        bus.is_ctrl_flow_i = ctrl;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        #1;
        chk({tag, "_valid"}, 128'(bus.decoded_instr_valid_o), 128'(1'b1));
        chk({tag, "_instr"}, 128'(bus.decoded_instr_o), 128'(mk(pc)));
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; resolve_branch_i = 1'b0;
        bus.instr_valid_i = 1'b0; bus.instr_i = '0; bus.is_ctrl_flow_i = 1'b0;
        bus.decoded_instr_ack_i = 1'b0;
        #12;
        chk("rst_valid", 128'(bus.decoded_instr_valid_o), 128'(1'b0));
        chk("rst_ctrl",  128'(bus.is_ctrl_flow_o), 128'(1'b0));
        chk("rst_ready", 128'(bus.instr_ready_o), 128'(1'b1));
        chk("rst_instr", 128'(bus.decoded_instr_o), 128'(0));
        chk("rst_cnt",   128'(dut.cnt_q), 128'(0));
        @(negedge clk_i); rst_ni = 1'b1;
        tick();

        // Streaming with ack held high
        bus.decoded_instr_ack_i = 1'b1;
        offer(32'h100, 1'b0); #1;
        chk("s_valid0", 128'(bus.decoded_instr_valid_o), 128'(1'b0));
        tick(); offer(32'h104, 1'b0); chk_head("s_100", 32'h100);
        tick(); offer(32'h108, 1'b0); chk_head("s_104", 32'h104);
        tick(); bus.instr_valid_i = 1'b0; chk_head("s_108", 32'h108);
        tick(); bus.decoded_instr_ack_i = 1'b0; #1;
        chk("s_cnt", 128'(dut.cnt_q), 128'(0));
        chk("s_empty", 128'(bus.decoded_instr_valid_o), 128'(1'b0));

        // Fill to full, back-pressure, no pass-through on simultaneous pop
        for (int i = 0; i < 4; i++) begin
            offer(32'h300 + 32'(4*i), 1'b0); #1;
            chk("f_ready", 128'(bus.instr_ready_o), 128'(1'b1));
            tick();
        end
        offer(32'h310, 1'b0); #1;
        chk("f_full_ready", 128'(bus.instr_ready_o), 128'(1'b0));
        chk("f_full_cnt", 128'(dut.cnt_q), 128'(4));
        tick(); #1;
        chk("f_5th_dropped", 128'(dut.cnt_q), 128'(4));
        bus.decoded_instr_ack_i = 1'b1; #1;
        chk("f_ackoffer_ready", 128'(bus.instr_ready_o), 128'(1'b0));
        tick(); bus.instr_valid_i = 1'b0; #1;
        chk("f_after_pop_cnt", 128'(dut.cnt_q), 128'(3));
        chk("f_ready_back", 128'(bus.instr_ready_o), 128'(1'b1));
        chk_head("f_304", 32'h304);
        tick(); chk_head("f_308", 32'h308);
        tick(); chk_head("f_30c", 32'h30C);
        tick(); bus.decoded_instr_ack_i = 1'b0; #1;
        chk("f_drained", 128'(dut.cnt_q), 128'(0));

        // Ctrl-flow stall; resolve alongside the ctrl-flow ack is ignored
        offer(32'h200, 1'b1); tick();
        offer(32'h204, 1'b0); tick();
        bus.instr_valid_i = 1'b0;
        bus.decoded_instr_ack_i = 1'b1; resolve_branch_i = 1'b1;
        chk_head("c_200", 32'h200);
        chk("c_ctrl", 128'(bus.is_ctrl_flow_o), 128'(1'b1));
        tick(); resolve_branch_i = 1'b0; #1;
        chk("c_wait_valid", 128'(bus.decoded_instr_valid_o), 128'(1'b0));
        tick(); #1;
        chk("c_ack_ignored", 128'(dut.cnt_q), 128'(1));
        bus.decoded_instr_ack_i = 1'b0; resolve_branch_i = 1'b1; #1;
        chk("c_resolve_cycle", 128'(bus.decoded_instr_valid_o), 128'(1'b0));
        tick(); resolve_branch_i = 1'b0;
        chk_head("c_204", 32'h204);
        chk("c_ctrl0", 128'(bus.is_ctrl_flow_o), 128'(1'b0));
        bus.decoded_instr_ack_i = 1'b1; tick(); bus.decoded_instr_ack_i = 1'b0;

        // Flush in WAIT_BR with 3 entries left, push in flush cycle dropped
        offer(32'h400, 1'b1); tick();
        offer(32'h404, 1'b0); tick();
        offer(32'h408, 1'b0); tick();
        offer(32'h40C, 1'b0); tick();
        bus.instr_valid_i = 1'b0; bus.decoded_instr_ack_i = 1'b1;
        tick(); bus.decoded_instr_ack_i = 1'b0; #1;
        chk("fl_pre_cnt", 128'(dut.cnt_q), 128'(3));
        chk("fl_pre_valid", 128'(bus.decoded_instr_valid_o), 128'(1'b0));
        flush_i = 1'b1; offer(32'h500, 1'b0); #1;
        chk("fl_ready", 128'(bus.instr_ready_o), 128'(1'b0));
        tick(); flush_i = 1'b0; bus.instr_valid_i = 1'b0; #1;
        chk("fl_cnt", 128'(dut.cnt_q), 128'(0));
        chk("fl_valid", 128'(bus.decoded_instr_valid_o), 128'(1'b0));
        offer(32'h600, 1'b0); tick(); bus.instr_valid_i = 1'b0;
        chk_head("fl_idle_600", 32'h600);
        bus.decoded_instr_ack_i = 1'b1; tick(); bus.decoded_instr_ack_i = 1'b0;

        // Wrap-around with a push and pop every cycle
        offer(32'h700, 1'b0); tick();
        bus.decoded_instr_ack_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(32'h704 + 32'(4*i), 1'b0);
            chk_head("w_head", 32'h700 + 32'(4*i));
            chk("w_cnt", 128'(dut.cnt_q), 128'(1));
            tick();
        end
        bus.instr_valid_i = 1'b0;
        chk_head("w_last", 32'h728);
        tick(); bus.decoded_instr_ack_i = 1'b0; #1;
        chk("w_cnt_end", 128'(dut.cnt_q), 128'(0));

        // Asynchronous reset mid-stream with an in-flight push
        offer(32'h800, 1'b0); tick();
        offer(32'h804, 1'b0); tick();
        offer(32'h808, 1'b0); #2;
        rst_ni = 1'b0; #1;
        chk("ar_valid", 128'(bus.decoded_instr_valid_o), 128'(1'b0));
        chk("ar_ready", 128'(bus.instr_ready_o), 128'(1'b1));
        chk("ar_instr", 128'(bus.decoded_instr_o), 128'(0));
        chk("ar_cnt", 128'(dut.cnt_q), 128'(0));
        tick(); #1;
        chk("ar_inflight", 128'(dut.cnt_q), 128'(0));
        @(negedge clk_i); rst_ni = 1'b1; bus.instr_valid_i = 1'b0;
        tick();
        offer(32'h900, 1'b0); tick(); bus.instr_valid_i = 1'b0;
        chk_head("ar_900", 32'h900);
        chk("ar_cnt1", 128'(dut.cnt_q), 128'(1));
        bus.decoded_instr_ack_i = 1'b1; tick(); bus.decoded_instr_ack_i = 1'b0; #1;
        chk("ar_cnt_end", 128'(dut.cnt_q), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
